// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [15:0] FETCH_NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE     = 5'b00000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcplus2;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry skid buffer holding one fetched IF/ID payload during a stall.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  unload,
  input  logic  clear,
  input  ifid_t din,
  output ifid_t dout,
  output logic  full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem read handshake, skid buffer and IF/ID register.
// Optional misaligned-fetch detection enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [15:0] imem_data,
  input  logic        imem_ready,
  output logic [15:0] Instruction_out,
  output logic [15:0] PcPlus2_out,
  output logic        Valid_out,
  output logic        err
);

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pcplus2: 16'h0000, valid: 1'b0};

  fetch_state_e state;
  logic [15:0]  pc;
  logic [15:0]  drain_addr;
  ifid_t        ifid;

  logic [15:0]  pc_plus2;
  logic         misaligned;
  logic         accept;
  logic         is_halt;
  ifid_t        fetched;

  logic         skid_load;
  logic         skid_unload;
  logic         skid_clear;
  logic         skid_full;
  ifid_t        skid_q;

  assign pc_plus2   = pc + 16'd2;
  assign imem_rd_en = ((state == FETCH) && !skid_full) || (state == DRAIN);
  assign imem_addr  = (state == DRAIN) ? drain_addr : pc;
  assign accept     = (state == FETCH) && !skid_full && imem_ready;
  assign is_halt    = (imem_data[15:11] == HALT_OPCODE);
  assign fetched    = '{instr: imem_data, pcplus2: pc_plus2, valid: !misaligned};

  assign skid_clear  = redirect_valid;
  assign skid_load   = !redirect_valid && stall && accept;
  assign skid_unload = !redirect_valid && !stall && skid_full;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (fetched),
    .dout   (skid_q),
    .full   (skid_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      ifid       <= BUBBLE;
    end else if (redirect_valid) begin
      pc   <= redirect_pc;
      ifid <= BUBBLE;
      // An in-flight read that is not finishing now must be drained at its old address.
      if (imem_rd_en && !imem_ready) begin
        state <= DRAIN;
        if (state != DRAIN) drain_addr <= pc;
      end else begin
        state <= FETCH;
      end
    end else begin
      unique case (state)
        DRAIN: begin
          ifid <= BUBBLE;
          if (imem_ready) state <= FETCH;
        end
        default: begin
          if (stall) begin
            if (accept) begin
              pc <= pc_plus2;
              if (is_halt) state <= HALTED;
            end
          end else if (skid_full) begin
            ifid <= skid_q;
          end else if (accept) begin
            ifid <= fetched;
            pc   <= pc_plus2;
            if (is_halt) state <= HALTED;
          end else begin
            ifid <= BUBBLE;
          end
        end
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = pc[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == FETCH) && imem_rd_en && pc[0]) begin
      err <= 1'b1;
    end
  end
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  assign Instruction_out = ifid.instr;
  assign PcPlus2_out     = ifid.pcplus2;
  assign Valid_out       = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-scenario stimulus tables with a scoreboard queue.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_data;
  logic        imem_ready;
  logic [15:0] Instruction_out;
  logic [15:0] PcPlus2_out;
  logic        Valid_out;
  logic        err;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        ready;
    logic [15:0] data;
    logic [15:0] e_instr;
    logic [15:0] e_pcp2;
    logic        e_valid;
    logic [15:0] e_addr;
    logic        e_rden;
  } vec_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcp2;
    logic        valid;
    logic [15:0] addr;
    logic        rden;
  } exp_t;

  exp_t sb[$];

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_addr       (imem_addr),
    .imem_rd_en      (imem_rd_en),
    .imem_data       (imem_data),
    .imem_ready      (imem_ready),
    .Instruction_out (Instruction_out),
    .PcPlus2_out     (PcPlus2_out),
    .Valid_out       (Valid_out),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rpc,
                              input logic rdy, input logic [15:0] d,
                              input logic [15:0] ei, input logic [15:0] ep, input logic ev,
                              input logic [15:0] ea, input logic er);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rpc; v.ready = rdy; v.data = d;
    v.e_instr = ei; v.e_pcp2 = ep; v.e_valid = ev; v.e_addr = ea; v.e_rden = er;
    return v;
  endfunction

  // Outputs are sampled 1 time unit after the rising edge, then new inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    stall          = v.stall;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    imem_ready     = v.ready;
    imem_data      = v.data;
    sb.push_back('{instr: v.e_instr, pcp2: v.e_pcp2, valid: v.e_valid,
                   addr: v.e_addr, rden: v.e_rden});
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_ready = 1'b0; imem_data = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    n_checks++;
    if ({Instruction_out, PcPlus2_out, Valid_out} !== {16'h0800, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ifid got %h/%h/%b exp 0800/0000/0", Instruction_out, PcPlus2_out, Valid_out);
    end
    n_checks++;
    if ({imem_addr, imem_rd_en, err} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ctrl got addr=%h rd_en=%b err=%b exp 0000/1/0", imem_addr, imem_rd_en, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    vec_t v[6];
    exp_t e;
    v[0] = mk(0, 0, 16'h0, 1, 16'h4001, 16'h4001, 16'h0002, 1, 16'h0002, 1);
    v[1] = mk(0, 0, 16'h0, 1, 16'h4102, 16'h4102, 16'h0004, 1, 16'h0004, 1);
    v[2] = mk(0, 0, 16'h0, 1, 16'h4203, 16'h4203, 16'h0006, 1, 16'h0006, 1);
    v[3] = mk(0, 0, 16'h0, 0, 16'h0000, 16'h0800, 16'h0000, 0, 16'h0006, 1);
    v[4] = mk(0, 0, 16'h0, 0, 16'h0000, 16'h0800, 16'h0000, 0, 16'h0006, 1);
    v[5] = mk(0, 0, 16'h0, 1, 16'h4304, 16'h4304, 16'h0008, 1, 16'h0008, 1);
    foreach (v[i]) begin
      apply(v[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({Instruction_out, PcPlus2_out, Valid_out} !== {e.instr, e.pcp2, e.valid}) begin
        n_fail++;
        $display("FAIL basic[%0d] ifid got %h/%h/%b exp %h/%h/%b", i,
                 Instruction_out, PcPlus2_out, Valid_out, e.instr, e.pcp2, e.valid);
      end
      n_checks++;
      if ({imem_addr, imem_rd_en} !== {e.addr, e.rden}) begin
        n_fail++;
        $display("FAIL basic[%0d] imem got %h/%b exp %h/%b", i, imem_addr, imem_rd_en, e.addr, e.rden);
      end
    end
  endtask

  task automatic test_stall_skid();
    vec_t v[5];
    exp_t e;
    v[0] = mk(1, 0, 16'h0, 1, 16'h4405, 16'h4304, 16'h0008, 1, 16'h000A, 0);
    v[1] = mk(1, 0, 16'h0, 1, 16'h7777, 16'h4304, 16'h0008, 1, 16'h000A, 0);
    v[2] = mk(1, 0, 16'h0, 1, 16'h7777, 16'h4304, 16'h0008, 1, 16'h000A, 0);
    v[3] = mk(0, 0, 16'h0, 1, 16'h7777, 16'h4405, 16'h000A, 1, 16'h000A, 1);
    v[4] = mk(0, 0, 16'h0, 1, 16'h4506, 16'h4506, 16'h000C, 1, 16'h000C, 1);
    foreach (v[i]) begin
      apply(v[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({Instruction_out, PcPlus2_out, Valid_out} !== {e.instr, e.pcp2, e.valid}) begin
        n_fail++;
        $display("FAIL stall[%0d] ifid got %h/%h/%b exp %h/%h/%b", i,
                 Instruction_out, PcPlus2_out, Valid_out, e.instr, e.pcp2, e.valid);
      end
      n_checks++;
      if ({imem_addr, imem_rd_en} !== {e.addr, e.rden}) begin
        n_fail++;
        $display("FAIL stall[%0d] imem got %h/%b exp %h/%b", i, imem_addr, imem_rd_en, e.addr, e.rden);
      end
    end
  endtask

  task automatic test_redirect_drain();
    vec_t v[4];
    exp_t e;
    v[0] = mk(0, 1, 16'h0100, 0, 16'h0000, 16'h0800, 16'h0000, 0, 16'h000C, 1);
    v[1] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0000, 0, 16'h000C, 1);
    v[2] = mk(0, 0, 16'h0000, 1, 16'h4607, 16'h0800, 16'h0000, 0, 16'h0100, 1);
    v[3] = mk(0, 0, 16'h0000, 1, 16'h4708, 16'h4708, 16'h0102, 1, 16'h0102, 1);
    foreach (v[i]) begin
      apply(v[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({Instruction_out, PcPlus2_out, Valid_out} !== {e.instr, e.pcp2, e.valid}) begin
        n_fail++;
        $display("FAIL drain[%0d] ifid got %h/%h/%b exp %h/%h/%b", i,
                 Instruction_out, PcPlus2_out, Valid_out, e.instr, e.pcp2, e.valid);
      end
      n_checks++;
      if ({imem_addr, imem_rd_en} !== {e.addr, e.rden}) begin
        n_fail++;
        $display("FAIL drain[%0d] imem got %h/%b exp %h/%b", i, imem_addr, imem_rd_en, e.addr, e.rden);
      end
    end
  endtask

  task automatic test_halt();
    vec_t v[4];
    exp_t e;
    v[0] = mk(0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0104, 1, 16'h0104, 0);
    v[1] = mk(0, 0, 16'h0000, 1, 16'h4444, 16'h0800, 16'h0000, 0, 16'h0104, 0);
    v[2] = mk(0, 1, 16'h0040, 0, 16'h0000, 16'h0800, 16'h0000, 0, 16'h0040, 1);
    v[3] = mk(0, 0, 16'h0000, 1, 16'h4809, 16'h4809, 16'h0042, 1, 16'h0042, 1);
    foreach (v[i]) begin
      apply(v[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({Instruction_out, PcPlus2_out, Valid_out} !== {e.instr, e.pcp2, e.valid}) begin
        n_fail++;
        $display("FAIL halt[%0d] ifid got %h/%h/%b exp %h/%h/%b", i,
                 Instruction_out, PcPlus2_out, Valid_out, e.instr, e.pcp2, e.valid);
      end
      n_checks++;
      if ({imem_addr, imem_rd_en} !== {e.addr, e.rden}) begin
        n_fail++;
        $display("FAIL halt[%0d] imem got %h/%b exp %h/%b", i, imem_addr, imem_rd_en, e.addr, e.rden);
      end
    end
  endtask

  task automatic test_wrap_and_stall_redirect();
    vec_t v[5];
    exp_t e;
    v[0] = mk(0, 1, 16'hFFFE, 1, 16'h5555, 16'h0800, 16'h0000, 0, 16'hFFFE, 1);
    v[1] = mk(0, 0, 16'h0000, 1, 16'h4A0B, 16'h4A0B, 16'h0000, 1, 16'h0000, 1);
    v[2] = mk(1, 0, 16'h0000, 1, 16'h4C00, 16'h4A0B, 16'h0000, 1, 16'h0002, 0);
    v[3] = mk(1, 1, 16'h0200, 0, 16'h0000, 16'h0800, 16'h0000, 0, 16'h0200, 1);
    v[4] = mk(0, 0, 16'h0000, 1, 16'h4D00, 16'h4D00, 16'h0202, 1, 16'h0202, 1);
    foreach (v[i]) begin
      apply(v[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({Instruction_out, PcPlus2_out, Valid_out} !== {e.instr, e.pcp2, e.valid}) begin
        n_fail++;
        $display("FAIL wrap[%0d] ifid got %h/%h/%b exp %h/%h/%b", i,
                 Instruction_out, PcPlus2_out, Valid_out, e.instr, e.pcp2, e.valid);
      end
      n_checks++;
      if ({imem_addr, imem_rd_en} !== {e.addr, e.rden}) begin
        n_fail++;
        $display("FAIL wrap[%0d] imem got %h/%b exp %h/%b", i, imem_addr, imem_rd_en, e.addr, e.rden);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_err got %b exp 0", err);
    end
  endtask

  task automatic test_rst_mid_drain();
    vec_t v[2];
    exp_t e;
    v[0] = mk(0, 1, 16'h0300, 0, 16'h0000, 16'h0800, 16'h0000, 0, 16'h0202, 1);
    v[1] = mk(0, 0, 16'h0000, 1, 16'h4F00, 16'h4F00, 16'h0002, 1, 16'h0002, 1);
    apply(v[0]);
    step();
    e = sb.pop_front();
    n_checks++;
    if ({imem_addr, imem_rd_en, Valid_out} !== {e.addr, e.rden, e.valid}) begin
      n_fail++;
      $display("FAIL rst_drain_enter got %h/%b/%b exp %h/%b/%b", imem_addr, imem_rd_en, Valid_out,
               e.addr, e.rden, e.valid);
    end
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    n_checks++;
    if ({imem_addr, imem_rd_en, Valid_out} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_drain_exit got %h/%b/%b exp 0000/1/0", imem_addr, imem_rd_en, Valid_out);
    end
    apply(v[1]);
    step();
    e = sb.pop_front();
    n_checks++;
    if ({Instruction_out, PcPlus2_out, Valid_out, imem_addr} !== {e.instr, e.pcp2, e.valid, e.addr}) begin
      n_fail++;
      $display("FAIL rst_drain_resume got %h/%h/%b/%h exp %h/%h/%b/%h", Instruction_out, PcPlus2_out,
               Valid_out, imem_addr, e.instr, e.pcp2, e.valid, e.addr);
    end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    vec_t v[3];
    exp_t e;
    v[0] = mk(0, 1, 16'h0011, 1, 16'h0000, 16'h0800, 16'h0000, 0, 16'h0011, 1);
    v[1] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0000, 0, 16'h0011, 1);
    v[2] = mk(0, 0, 16'h0000, 1, 16'h4E00, 16'h4E00, 16'h0013, 0, 16'h0013, 1);
    foreach (v[i]) begin
      apply(v[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({Instruction_out, PcPlus2_out, Valid_out} !== {e.instr, e.pcp2, e.valid}) begin
        n_fail++;
        $display("FAIL align[%0d] ifid got %h/%h/%b exp %h/%h/%b", i,
                 Instruction_out, PcPlus2_out, Valid_out, e.instr, e.pcp2, e.valid);
      end
      if (i > 0) begin
        n_checks++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("FAIL align_err[%0d] got %b exp 1", i, err);
        end
      end
    end
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL align_err_clear got %b exp 0", err);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_fetch();
    test_stall_skid();
    test_redirect_drain();
    test_halt();
    test_wrap_and_stall_redirect();
    test_rst_mid_drain();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
